// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg -- shared definitions for the two-port data RAM arbiter.
//
// Contents:
//   NUM_PORTS / PORT_W   number of requesters and width of a port index
//   PORT_CPU / PORT_LDR  port index of the CPU (0) and the program loader (1)
//   arb_state_e          sequencer states IDLE, WR, RD, RD_DATA
//   port_onehot()        port index -> one-hot ack vector
//   other_port()         the opposite port of a two-port pair
//
// Optional feature macro used by the files that import this package:
//   ARB_RR_EN (round-robin arbitration instead of fixed priority)
package ram_arb_pkg;

  localparam int NUM_PORTS = 2;
  localparam int PORT_W    = 1;

  typedef logic [PORT_W-1:0] port_idx_t;

  localparam port_idx_t PORT_CPU = 1'b0;
  localparam port_idx_t PORT_LDR = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD      = 2'd2,
    RD_DATA = 2'd3
  } arb_state_e;

  function automatic logic [NUM_PORTS-1:0] port_onehot(input port_idx_t p);
    logic [NUM_PORTS-1:0] oh;
    oh    = {NUM_PORTS{1'b0}};
    oh[p] = 1'b1;
    return oh;
  endfunction

  function automatic port_idx_t other_port(input port_idx_t p);
    return ~p;
  endfunction

endpackage

// File: rtl/ram_arbiter_arb_pick.sv
// arb_pick -- combinational winner selection between the two requesters.
//
// Ports:
//   req_i    in  NUM_PORTS  live request bits, bit n = port n
//   last_i   in  PORT_W     port granted most recently
//   win_o    out PORT_W     winning port index (meaningful when valid_o)
//   valid_o  out 1          at least one port is requesting
//
// Macro ARB_RR_EN: defined -> on a conflict the port not granted last wins;
// undefined -> port 0 (CPU) always wins a conflict and last_i is ignored.
module arb_pick
  import ram_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [PORT_W-1:0]    last_i,
  output logic [PORT_W-1:0]    win_o,
  output logic                 valid_o
);

  // Winner selection: a lone requester always wins; a conflict goes to the policy.
  always_comb begin
    valid_o = |req_i;
    win_o   = PORT_CPU;
    if (req_i == 2'b11) begin
`ifdef ARB_RR_EN
      win_o = other_port(last_i);
`else
      win_o = PORT_CPU;
`endif
    end else if (req_i[PORT_LDR]) begin
      win_o = PORT_LDR;
    end else begin
      win_o = PORT_CPU;
    end
  end

`ifndef ARB_RR_EN
  // Fixed priority has no use for the pointer; fold it into a sink net.
  logic unused_last_s;
  assign unused_last_s = ^last_i;
`endif

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter -- sequencing controller and two-port arbiter for the 256x8
// synchronous data RAM. Port 0 is the CPU, port 1 the program loader/debug port.
//
// Ports:
//   clk          in   clock, all state changes on the rising edge
//   rst          in   asynchronous active-low reset
//   req / we     in   per-port request and direction (1 = write)
//   addr / wdata in   per-port command, port n at [n*W +: W]
//   ack          out  one-cycle completion pulse to the granted port
//   rdata        out  read data, valid while ack is high for a read
//   busy         out  high whenever the sequencer is not in IDLE
//   mem_wr_en    out  RAM write strobe
//   mem_rd_en    out  RAM read strobe (RAM latches the address on this edge)
//   mem_addr     out  RAM address from the command register
//   mem_wdata    out  write data from the command register
//   mem_data_oe  out  drive mem_wdata onto the RAM bus
//   mem_rdata    in   RAM data bus as read back by the top level
//
// Macro ARB_RR_EN: defined -> round-robin arbitration with a last-grant
// pointer register; undefined -> fixed priority (port 0 wins), no pointer.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          req,
  input  logic [NUM_PORTS-1:0]          we,
  input  logic [NUM_PORTS*ADDR_W-1:0]   addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   wdata,
  output logic [NUM_PORTS-1:0]          ack,
  output logic [DATA_W-1:0]             rdata,
  output logic                          busy,
  output logic                          mem_wr_en,
  output logic                          mem_rd_en,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic                          mem_data_oe,
  input  logic [DATA_W-1:0]             mem_rdata
);

  arb_state_e           state_q;
  port_idx_t            cmd_port_q;
  logic                 cmd_we_q;
  logic [ADDR_W-1:0]    cmd_addr_q;
  logic [DATA_W-1:0]    cmd_wdata_q;
  logic [NUM_PORTS-1:0] ack_q;
  logic                 wr_en_q;
  logic                 rd_en_q;
  logic                 oe_q;
  logic                 busy_q;

  port_idx_t            last_s;
  port_idx_t            pick_win_s;
  logic                 pick_valid_s;
  logic                 pick_we_s;
  logic [ADDR_W-1:0]    pick_addr_s;
  logic [DATA_W-1:0]    pick_wdata_s;

  arb_pick u_arb_pick (
    .req_i   (req),
    .last_i  (last_s),
    .win_o   (pick_win_s),
    .valid_o (pick_valid_s)
  );

  // Route the winning port's command fields toward the command registers.
  always_comb begin
    pick_we_s    = we[PORT_CPU];
    pick_addr_s  = addr[0 +: ADDR_W];
    pick_wdata_s = wdata[0 +: DATA_W];
    if (pick_win_s == PORT_LDR) begin
      pick_we_s    = we[PORT_LDR];
      pick_addr_s  = addr[ADDR_W +: ADDR_W];
      pick_wdata_s = wdata[DATA_W +: DATA_W];
    end else begin
      pick_we_s    = we[PORT_CPU];
      pick_addr_s  = addr[0 +: ADDR_W];
      pick_wdata_s = wdata[0 +: DATA_W];
    end
  end

`ifdef ARB_RR_EN
  port_idx_t last_q;

  // Last-grant pointer: reset to the loader so the CPU wins the first conflict.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= PORT_LDR;
    end else if ((state_q == IDLE) && pick_valid_s) begin
      last_q <= pick_win_s;
    end else begin
      last_q <= last_q;
    end
  end

  assign last_s = last_q;
`else
  assign last_s = PORT_LDR;
`endif

  // Transaction sequencer: one state per RAM cycle, outputs registered with the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cmd_port_q  <= PORT_CPU;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= {ADDR_W{1'b0}};
      cmd_wdata_q <= {DATA_W{1'b0}};
      ack_q       <= {NUM_PORTS{1'b0}};
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid_s) begin
            cmd_port_q  <= pick_win_s;
            cmd_we_q    <= pick_we_s;
            cmd_addr_q  <= pick_addr_s;
            cmd_wdata_q <= pick_wdata_s;
            busy_q      <= 1'b1;
            if (pick_we_s) begin
              // A write completes in its strobe cycle, so ack rides along.
              state_q <= WR;
              ack_q   <= port_onehot(pick_win_s);
              wr_en_q <= 1'b1;
              oe_q    <= 1'b1;
              rd_en_q <= 1'b0;
            end else begin
              state_q <= RD;
              ack_q   <= {NUM_PORTS{1'b0}};
              wr_en_q <= 1'b0;
              oe_q    <= 1'b0;
              rd_en_q <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
            ack_q   <= {NUM_PORTS{1'b0}};
            wr_en_q <= 1'b0;
            oe_q    <= 1'b0;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        WR: begin
          state_q <= IDLE;
          ack_q   <= {NUM_PORTS{1'b0}};
          wr_en_q <= 1'b0;
          oe_q    <= 1'b0;
          rd_en_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        RD: begin
          // RAM data appears one cycle after the read strobe edge.
          state_q <= RD_DATA;
          ack_q   <= port_onehot(cmd_port_q);
          wr_en_q <= 1'b0;
          oe_q    <= 1'b0;
          rd_en_q <= 1'b0;
          busy_q  <= 1'b1;
        end
        RD_DATA: begin
          state_q <= IDLE;
          ack_q   <= {NUM_PORTS{1'b0}};
          wr_en_q <= 1'b0;
          oe_q    <= 1'b0;
          rd_en_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ack_q   <= {NUM_PORTS{1'b0}};
          wr_en_q <= 1'b0;
          oe_q    <= 1'b0;
          rd_en_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Read data is a pass-through of the RAM bus, gated to the read-ack cycle.
  always_comb begin
    if ((state_q == RD_DATA) && !cmd_we_q) begin
      rdata = mem_rdata;
    end else begin
      rdata = {DATA_W{1'b0}};
    end
  end

  assign ack         = ack_q;
  assign busy        = busy_q;
  assign mem_wr_en   = wr_en_q;
  assign mem_rd_en   = rd_en_q;
  assign mem_data_oe = oe_q;
  assign mem_addr    = cmd_addr_q;
  assign mem_wdata   = cmd_wdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter -- self-checking bench for ram_arbiter with a transaction-level
// model: each granted command lives for a fixed number of cycles (write 1, read 2)
// and the expected strobes/acks follow from its age. Honours ARB_RR_EN.
module tb_ram_arbiter;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [1:0]  we = 2'b00;
  logic [15:0] addr = 16'h0000;
  logic [15:0] wdata = 16'h0000;
  logic [1:0]  ack;
  logic [7:0]  rdata;
  logic        busy;
  logic        mem_wr_en;
  logic        mem_rd_en;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_data_oe;
  logic [7:0]  mem_rdata;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .busy(busy), .mem_wr_en(mem_wr_en),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_data_oe(mem_data_oe), .mem_rdata(mem_rdata)
  );

  // Synchronous 256x8 RAM with one-cycle read latency.
  logic [7:0] ram [256];
  logic [7:0] ram_q = 8'h00;
  always @(posedge clk) begin
    if (mem_wr_en) ram[mem_addr] <= mem_wdata;
    if (mem_rd_en) ram_q <= ram[mem_addr];
  end
  assign mem_rdata = ram_q;

  // Requester queues and bookkeeping
  cmd_t pq [2][$];
  int   issued [2];
  int   dut_acks [2];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   ack_order [$];
  logic [7:0] last_rd = 8'h00;

  // Behavioural model
  bit         m_active;
  int         m_age;
  int         m_port;
  bit         m_we;
  logic [7:0] m_addr;
  logic [7:0] m_wdata;
  logic [7:0] m_rexp;
  bit         m_rvalid;
  int         m_last;
  logic [7:0] mmem [256];
  bit         mwr [256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_age    = 0;
    m_port   = 0;
    m_we     = 1'b0;
    m_addr   = 8'h00;
    m_wdata  = 8'h00;
    m_last   = 1;
  endtask

  task automatic enq(input int p, input bit w, input logic [7:0] a, input logic [7:0] d);
    cmd_t c;
    c.we = w; c.addr = a; c.wdata = d;
    pq[p].push_back(c);
    issued[p]++;
  endtask

  task automatic drive();
    logic [1:0]  r;
    logic [1:0]  w;
    logic [15:0] a;
    logic [15:0] d;
    r = 2'b00; w = 2'b00; a = 16'h0000; d = 16'h0000;
    for (int p = 0; p < 2; p++) begin
      if (pq[p].size() > 0) begin
        r[p] = 1'b1;
        w[p] = pq[p][0].we;
        a[p*8 +: 8] = pq[p][0].addr;
        d[p*8 +: 8] = pq[p][0].wdata;
      end
    end
    req = r; we = w; addr = a; wdata = d;
  endtask

  task automatic abort_all();
    for (int p = 0; p < 2; p++) begin
      issued[p] -= pq[p].size();
      pq[p].delete();
    end
    drive();
    model_reset();
  endtask

  // One clock cycle: compare DUT against the model, retire acked commands,
  // present the next inputs and let the model react to the coming edge.
  task automatic step();
    logic [1:0] e_ack;
    bit e_wr, e_rd, e_rdack;
    int win;
    @(negedge clk);
    cyc++;
    e_ack = 2'b00; e_wr = 1'b0; e_rd = 1'b0; e_rdack = 1'b0;
    if (m_active) begin
      if (m_we) begin
        e_wr = 1'b1; e_ack[m_port] = 1'b1;
      end else if (m_age == 1) begin
        e_rd = 1'b1;
      end else begin
        e_ack[m_port] = 1'b1; e_rdack = 1'b1;
      end
    end
    chk("ack", ack, e_ack);
    chk("busy", busy, m_active);
    chk("mem_wr_en", mem_wr_en, e_wr);
    chk("mem_rd_en", mem_rd_en, e_rd);
    chk("mem_data_oe", mem_data_oe, e_wr);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("strobe_excl", mem_wr_en & mem_rd_en, 1'b0);
    if (e_rdack && m_rvalid) chk("rdata", rdata, m_rexp);
    for (int p = 0; p < 2; p++) if (ack[p]) dut_acks[p]++;
    if (ack == 2'b01) ack_order.push_back(0);
    if (ack == 2'b10) ack_order.push_back(1);
    if (e_rdack) last_rd = rdata;
    if (e_ack != 2'b00) void'(pq[m_port].pop_front());
    drive();
    if (m_active) begin
      if (m_we || m_age == 2) m_active = 1'b0;
      else m_age++;
    end else if (req != 2'b00) begin
      if (req == 2'b11) begin
`ifdef ARB_RR_EN
        win = 1 - m_last;
`else
        win = 0;
`endif
      end else begin
        win = req[1] ? 1 : 0;
      end
      m_last   = win;
      m_active = 1'b1;
      m_age    = 1;
      m_port   = win;
      m_we     = pq[win][0].we;
      m_addr   = pq[win][0].addr;
      m_wdata  = pq[win][0].wdata;
      if (m_we) begin
        mmem[m_addr] = m_wdata; mwr[m_addr] = 1'b1;
      end else begin
        m_rexp = mmem[m_addr]; m_rvalid = mwr[m_addr];
      end
    end
  endtask

  task automatic run_until_idle(input int max);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while ((pq[0].size() > 0 || pq[1].size() > 0 || m_active) && n < max);
    chk("timeout_pending", pq[0].size() + pq[1].size() + int'(m_active), 0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b0;
    abort_all();
    #1;
    chk("rst_ack", ack, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wr", mem_wr_en, 1'b0);
    chk("rst_rd", mem_rd_en, 1'b0);
    chk("rst_oe", mem_data_oe, 1'b0);
    chk("rst_addr", mem_addr, 8'h00);
    chk("rst_wdata", mem_wdata, 8'h00);
    chk("rst_rdata", rdata, 8'h00);
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic logic [7:0] rnd_addr();
    int a;
    a = $urandom_range(0, 31);
    if (a >= 16) a = a + 224;
    return a[7:0];
  endfunction

  initial begin
    int pos;
    int total;
    int guard;
    issued[0] = 0; issued[1] = 0; dut_acks[0] = 0; dut_acks[1] = 0;
    model_reset();
    reset_dut();

    // Single write then read on port 0
    enq(0, 1'b1, 8'h10, 8'h5A);
    step();
    step();
    chk("t1_wr_ack", ack, 2'b01);
    chk("t1_wr_en", mem_wr_en, 1'b1);
    enq(0, 1'b0, 8'h10, 8'h00);
    step();
    step();
    chk("t1_rd_strobe", mem_rd_en, 1'b1);
    step();
    chk("t1_rd_ack", ack, 2'b01);
    chk("t1_rdata", rdata, 8'h5A);
    run_until_idle(10);

    // Conflicting writes from a fresh reset: port 0 first, then port 1
    reset_dut();
    ack_order.delete();
    enq(0, 1'b1, 8'h20, 8'h11);
    enq(1, 1'b1, 8'h21, 8'h22);
    run_until_idle(20);
    chk("conf_n_acks", ack_order.size(), 2);
    chk("conf_first", ack_order[0], 0);
    chk("conf_second", ack_order[1], 1);
    enq(0, 1'b0, 8'h20, 8'h00);
    run_until_idle(10);
    chk("conf_rd20", last_rd, 8'h11);
    enq(1, 1'b0, 8'h21, 8'h00);
    run_until_idle(10);
    chk("conf_rd21", last_rd, 8'h22);

    // Port 0 streams reads while port 1 holds a read request
    reset_dut();
    ack_order.delete();
    for (int i = 0; i < 10; i++) enq(0, 1'b0, 8'h20, 8'h00);
    enq(1, 1'b0, 8'h21, 8'h00);
    run_until_idle(100);
    pos = -1;
    for (int i = 0; i < ack_order.size(); i++) if (ack_order[i] == 1 && pos < 0) pos = i;
    chk("stream_n_acks", ack_order.size(), 11);
`ifdef ARB_RR_EN
    chk("stream_port1_pos", pos, 1);
`else
    chk("stream_port1_pos", pos, 10);
`endif

    // Boundary addresses
    enq(0, 1'b1, 8'h00, 8'h01);
    enq(0, 1'b1, 8'hFF, 8'hFF);
    run_until_idle(20);
    enq(1, 1'b0, 8'hFF, 8'h00);
    run_until_idle(10);
    chk("bound_rdFF", last_rd, 8'hFF);
    enq(1, 1'b0, 8'h00, 8'h00);
    run_until_idle(10);
    chk("bound_rd00", last_rd, 8'h01);

    // Reset during the RD state
    enq(1, 1'b0, 8'h10, 8'h00);
    step();
    @(posedge clk);
    #2;
    chk("midrst_pre_rd", mem_rd_en, 1'b1);
    rst = 1'b0;
    #1;
    chk("midrst_rd", mem_rd_en, 1'b0);
    chk("midrst_ack", ack, 2'b00);
    chk("midrst_busy", busy, 1'b0);
    abort_all();
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("midrst_busy_after", busy, 1'b0);
    ack_order.delete();
    enq(1, 1'b0, 8'h20, 8'h00);
    run_until_idle(10);
    chk("midrst_new_rd", last_rd, 8'h11);
    chk("midrst_new_port", ack_order[0], 1);

    // Random traffic across both ports
    reset_dut();
    total = 0;
    guard = 0;
    while (total < 200 && guard < 4000) begin
      for (int p = 0; p < 2; p++) begin
        if (total < 200 && pq[p].size() < 3 && $urandom_range(0, 2) == 0) begin
          enq(p, 1'($urandom_range(0, 1)), rnd_addr(), 8'($urandom_range(0, 255)));
          total++;
        end
      end
      step();
      guard++;
    end
    run_until_idle(2000);
    chk("rand_issued", total, 200);
    for (int p = 0; p < 2; p++) chk($sformatf("ack_count_p%0d", p), dut_acks[p], issued[p]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion before 1000000");
    $fatal(1);
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Sequencing controller and two-port arbiter for the 256×8 synchronous data RAM (`wr_en`/`rd_en`/`addr`/`data` interface) of the 8-bit CPU. It accepts single-byte read and write requests from two requesters: port 0 is the CPU, port 1 is the program loader/debug port. It serialises these requests onto the single RAM port and generates the RAM strobes with the RAM's one-cycle read-address latency. It also drives the output-enable the top level uses to steer the RAM's bidirectional data bus.

## Interface
- `ADDR_W`, 8, address width; RAM depth = 2^ADDR_W
- `DATA_W`, 8, data width

- `clk`  in  1  single clock; all state changes on the rising edge
- `rst`  in  1  asynchronous, active-low reset; `rst`=0 resets immediately, independent of `clk`
- `req`  in  2  per-port request; bit n = port n; held high until that port's `ack`
- `we`  in  2  per-port direction: 1 = write, 0 = read; stable while `req` is high
- `addr`  in  2*ADDR_W  port n occupies `[n*ADDR_W +: ADDR_W]`
- `wdata`  in  2*DATA_W  port n occupies `[n*DATA_W +: DATA_W]`
- `ack`  out  2  one-cycle completion pulse to the granted port
- `rdata`  out  DATA_W  read data; valid only in a cycle where `ack` is high for a read
- `busy`  out  1  high in any state other than IDLE
- `mem_wr_en`  out  1  RAM write strobe
- `mem_rd_en`  out  1  RAM read strobe; RAM latches the address on this edge
- `mem_addr`  out  ADDR_W  RAM address
- `mem_wdata`  out  DATA_W  write data toward the RAM bus
- `mem_data_oe`  out  1  top level drives `mem_wdata` onto the RAM data bus when high
- `mem_rdata`  in  DATA_W  RAM data bus as read back by the top level

## Operation
- The FSM has four states.
  - IDLE: if any `req` bit is set, pick a winner and latch its `we`, `addr` and `wdata` into command registers. Go to WR if `we`=1, otherwise go to RD. With no request, stay in IDLE.
  - WR: `mem_wr_en`=1 and `mem_data_oe`=1. `ack[winner]`=1. Go to IDLE.
  - RD: `mem_rd_en`=1. Go to RD_DATA.
  - RD_DATA: `rdata` = `mem_rdata` (combinational pass-through). `ack[winner]`=1. Go to IDLE.
- `mem_addr` and `mem_wdata` always come from the command registers, never from the live port inputs.
- Requesters must drop `req` (or present a new command) on the edge where they see `ack`. The arbiter never samples `req` outside IDLE.
- The arbiter does not combine reads and writes into one transaction and does not reorder requests within a port.
- Reset values:
  - state = IDLE
  - `ack`=0, `mem_wr_en`=0, `mem_rd_en`=0, `mem_data_oe`=0, `busy`=0
  - `mem_addr`=0, `mem_wdata`=0, `rdata`=0
  - last-grant pointer = port 1, so port 0 wins the first conflict
- Reset mid-transaction aborts the transaction. Strobes drop asynchronously and no `ack` is issued. A write aborted this way may or may not have committed.
- Simultaneous requests are resolved by the selected arbitration policy (see Configuration).
- `addr` wraps naturally: 0xFF is a legal address, and there is no out-of-range case.

## Timing
- Latency is counted from the edge where IDLE samples `req`.
  - Write: `ack` is high in the next cycle (WR). The RAM commits at the end of that cycle.
  - Read: `ack` and valid `rdata` are high two cycles later (RD_DATA).
- Throughput for back-to-back transactions:
  - Write: 2 cycles per write.
  - Read: 3 cycles per read.
- `mem_wr_en` and `mem_rd_en` are never high together, and each is high for exactly one cycle per transaction.
- `mem_data_oe` equals `mem_wr_en`.

## Configuration
- `ARB_RR_EN` selects the arbitration policy.
  - Defined: round-robin. On a conflict, the port not granted last wins. The pointer updates on every grant.
  - Undefined: fixed priority. Port 0 always wins a conflict. The pointer register is not built.

## Structure
- Package `ram_arb_pkg` holds:
  - the state enum (IDLE, WR, RD, RD_DATA)
  - `NUM_PORTS` = 2
  - port index constants `PORT_CPU` = 0 and `PORT_LDR` = 1
- One sub-module, `arb_pick`: purely combinational. Inputs are `req` and the last-grant pointer; outputs are the winner index and a valid flag. It holds the `ARB_RR_EN` split.
- The FSM, command registers and output decode stay in `ram_arbiter`.

## Test plan
- Single write then read: port 0 writes 0x5A to 0x10, then reads 0x10.
  - `ack[0]` pulses in cycle 1 with `mem_wr_en`=1.
  - On the read, `ack[0]` is high in cycle 2 with `rdata`=0x5A.
- Conflict with `ARB_RR_EN` defined: both ports request writes in the same cycle (port 0: 0x11 to 0x20; port 1: 0x22 to 0x21), and both hold `req`.
  - Port 0 is served first, then port 1.
  - Reading back gives 0x11 at 0x20 and 0x22 at 0x21.
- Fixed priority (`ARB_RR_EN` undefined): port 0 issues continuous reads while port 1 holds `req`.
  - Port 1 is never acked while port 0 keeps re-requesting.
- Boundary address: write 0xFF to address 0xFF, then read address 0x00 (pre-written 0x01).
  - The reads return 0xFF and 0x01 respectively; there is no aliasing.
- Reset mid-read: `rst` goes low in the RD state.
  - `mem_rd_en` drops immediately and no `ack` is issued.
  - After release, `busy`=0 and a new port 1 read completes normally.
- Strobe exclusivity: a random mix of 200 transactions across both ports.
  - `mem_wr_en` and `mem_rd_en` are never high together.
  - Exactly one `ack` per request.
  - All reads match a scoreboard memory model.
